// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencer with EX/MEM/WB destination scoreboard,
// forwarding selects, load-use stalls, redirect flushes, freezes and exception drain.
module hazard_ctrl #(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr_top,
    input  logic [4:0]  id_dst,
    input  logic        id_regwrite,
    input  logic        id_memread,
    input  logic        ex_redirect,
    input  logic        exc_req,
    input  logic        mem_busy,
    output logic        pc_we,
    output logic        if_we,
    output logic        id_we,
    output logic        if_flush,
    output logic        id_flush,
    output logic [1:0]  ctrl_rs,
    output logic [1:0]  ctrl_rt,
    output logic        exc_take
);
    typedef enum logic [1:0] {RUN, DRAIN, TAKE} state_t;
    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
        logic       regwrite;
        logic       memread;
    } slot_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    slot_t      ex_q, mem_q, wb_q, ex_d, mem_d, wb_d;
    logic [5:0] op;
    logic [4:0] rs, rt;
    logic       uses_rs, uses_rt, load_use;

    assign op = instr_top[15:10];
    assign rs = instr_top[9:5];
    assign rt = instr_top[4:0];
    assign uses_rs = !(op == 6'b000010 || op == 6'b000011 || op == 6'b001111);
    assign uses_rt = op == 6'b000000 || op == 6'b000100 || op == 6'b000101 ||
                     op == 6'b101011 || op == 6'b101000;
    assign load_use = ex_q.valid && ex_q.memread && ex_q.dst != 5'd0 &&
                      ((uses_rs && ex_q.dst == rs) || (uses_rt && ex_q.dst == rt));

    // Youngest matching producer wins, so EX is checked before MEM and WB.
    function automatic logic [1:0] fwd(input logic [4:0] r, input slot_t e, input slot_t m,
                                       input slot_t w);
        return (r == 5'd0) ? 2'd0 :
               (e.valid && e.regwrite && e.dst == r) ? 2'd1 :
               (m.valid && m.regwrite && m.dst == r) ? 2'd2 :
               (w.valid && w.regwrite && w.dst == r) ? 2'd3 : 2'd0;
    endfunction

    always_comb begin
        pc_we    = 1'b1;
        if_we    = 1'b1;
        id_we    = 1'b1;
        if_flush = 1'b0;
        id_flush = 1'b0;
        exc_take = 1'b0;
        ctrl_rs  = fwd(rs, ex_q, mem_q, wb_q);
        ctrl_rt  = fwd(rt, ex_q, mem_q, wb_q);
        state_d  = state_q;
        cnt_d    = cnt_q;
        if (reset) begin
            {pc_we, if_we, id_we} = 3'b000;
            {if_flush, id_flush}  = 2'b11;
            ctrl_rs = 2'd0;
            ctrl_rt = 2'd0;
        end else if (mem_busy) begin
            {pc_we, if_we, id_we, if_flush, id_flush} = 5'b00000;
        end else begin
            case (state_q)
                RUN: begin
                    if (exc_req) begin
                        {pc_we, if_we, id_we, if_flush, id_flush} = 5'b00011;
                        cnt_d   = 3'(DRAIN_CYCLES - 1);
                        state_d = DRAIN;
                    end else if (ex_redirect) begin
                        {pc_we, if_we, id_we, if_flush, id_flush} = 5'b10011;
                    end else if (load_use) begin
                        {pc_we, if_we, id_we, if_flush, id_flush} = 5'b00001;
                    end
                end
                DRAIN: begin
                    {pc_we, if_we, id_we, if_flush, id_flush} = 5'b00011;
                    cnt_d   = (cnt_q == 3'd0) ? cnt_q : cnt_q - 3'd1;
                    state_d = (cnt_q == 3'd0) ? TAKE : DRAIN;
                end
                TAKE: begin
                    {pc_we, if_we, id_we, if_flush, id_flush} = 5'b10011;
                    exc_take = 1'b1;
                    state_d  = RUN;
                end
                default: state_d = RUN;
            endcase
        end
        wb_d  = mem_busy ? wb_q  : mem_q;
        mem_d = mem_busy ? mem_q : ex_q;
        ex_d  = mem_busy ? ex_q  :
                (id_we && !id_flush) ? {1'b1, id_dst, id_regwrite, id_memread} : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios plus randomized cycles against a behavioural
// model of the pipeline sequencer (slot array and exception countdown).
module tb_hazard_ctrl;
    localparam int DC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr_top;
    logic [4:0]  id_dst;
    logic        id_regwrite, id_memread, ex_redirect, exc_req, mem_busy;
    logic        pc_we, if_we, id_we, if_flush, id_flush, exc_take;
    logic [1:0]  ctrl_rs, ctrl_rt;

    int checks = 0;
    int errors = 0;

    hazard_ctrl #(.DRAIN_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .instr_top(instr_top), .id_dst(id_dst),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_redirect(ex_redirect),
        .exc_req(exc_req), .mem_busy(mem_busy), .pc_we(pc_we), .if_we(if_we),
        .id_we(id_we), .if_flush(if_flush), .id_flush(id_flush), .ctrl_rs(ctrl_rs),
        .ctrl_rt(ctrl_rt), .exc_take(exc_take)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit v;
        int dst;
        bit rw;
        bit mr;
    } mslot_t;

    mslot_t sb[3];
    bit     m_exc;
    int     m_left;
    logic   e_pc, e_if, e_id, e_iff, e_idf, e_take;
    logic [1:0] e_rs, e_rt;

    function automatic logic [1:0] m_fwd(input int r);
        if (r == 0) return 2'd0;
        for (int i = 0; i < 3; i++)
            if (sb[i].v && sb[i].rw && sb[i].dst == r) return 2'(i + 1);
        return 2'd0;
    endfunction

    task automatic model_eval();
        int op, rs, rt;
        bit urs, urt, lu;
        op = int'(instr_top[15:10]);
        rs = int'(instr_top[9:5]);
        rt = int'(instr_top[4:0]);
        urs = !(op == 2 || op == 3 || op == 15);
        urt = (op == 0 || op == 4 || op == 5 || op == 43 || op == 40);
        lu = sb[0].v && sb[0].mr && sb[0].dst != 0 &&
             ((urs && sb[0].dst == rs) || (urt && sb[0].dst == rt));
        {e_pc, e_if, e_id, e_iff, e_idf, e_take} = 6'b111000;
        e_rs = m_fwd(rs);
        e_rt = m_fwd(rt);
        if (reset) begin
            {e_pc, e_if, e_id, e_iff, e_idf} = 5'b00011;
            e_rs = 0;
            e_rt = 0;
        end else if (mem_busy) {e_pc, e_if, e_id, e_iff, e_idf} = 5'b00000;
        else if (m_exc && m_left > 0) {e_pc, e_if, e_id, e_iff, e_idf} = 5'b00011;
        else if (m_exc) {e_pc, e_if, e_id, e_iff, e_idf, e_take} = 6'b100111;
        else if (exc_req) {e_pc, e_if, e_id, e_iff, e_idf} = 5'b00011;
        else if (ex_redirect) {e_pc, e_if, e_id, e_iff, e_idf} = 5'b10011;
        else if (lu) {e_pc, e_if, e_id, e_iff, e_idf} = 5'b00001;
    endtask

    task automatic model_step();
        if (reset) begin
            for (int i = 0; i < 3; i++) sb[i] = '{0, 0, 0, 0};
            m_exc = 0;
            m_left = 0;
        end else if (!mem_busy) begin
            sb[2] = sb[1];
            sb[1] = sb[0];
            sb[0] = (e_id && !e_idf) ? '{1, int'(id_dst), id_regwrite, id_memread}
                                     : '{0, 0, 0, 0};
            if (m_exc && m_left > 0) m_left--;
            else if (m_exc) m_exc = 0;
            else if (exc_req) begin
                m_exc = 1;
                m_left = DC;
            end
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] dst, input logic rw, input logic mr,
                         input logic redir, input logic exc, input logic busy,
                         input logic rst);
        @(negedge clk);
        instr_top = {op, rs, rt};
        id_dst = dst;
        id_regwrite = rw;
        id_memread = mr;
        ex_redirect = redir;
        exc_req = exc;
        mem_busy = busy;
        reset = rst;
        #1 model_eval();
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(6'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
            tick();
        end
    endtask

    task automatic test_reset();
        drive(6'd0, 5'd1, 5'd1, 5'd0, 0, 0, 0, 0, 0, 1);
        checks++;
        if ({pc_we, if_we, id_we, if_flush, id_flush, ctrl_rs, ctrl_rt, exc_take} !== 10'b0001100000) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0001100000",
                     {pc_we, if_we, id_we, if_flush, id_flush, ctrl_rs, ctrl_rt, exc_take});
        end
        tick();
        drive(6'd0, 5'd1, 5'd2, 5'd0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({pc_we, if_we, id_we, if_flush, id_flush, ctrl_rs, ctrl_rt} !== 9'b111000000) begin
            errors++;
            $display("FAIL reset_release got %b want 111000000",
                     {pc_we, if_we, id_we, if_flush, id_flush, ctrl_rs, ctrl_rt});
        end
        tick();
        idle(3);
    endtask

    task automatic test_fwd_chain();
        logic [1:0] want[4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        drive(6'd0, 5'd0, 5'd0, 5'd3, 1, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(6'd0, 5'd3, 5'd0, 5'd10, 0, 0, 0, 0, 0, 0);
            checks++;
            if (ctrl_rs !== want[i]) begin
                errors++;
                $display("FAIL fwd_rs_%0d got %0d want %0d", i, ctrl_rs, want[i]);
            end
            tick();
        end
        drive(6'd0, 5'd0, 5'd0, 5'd4, 1, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(6'd0, 5'd0, 5'd4, 5'd10, 0, 0, 0, 0, 0, 0);
            checks++;
            if (ctrl_rt !== want[i]) begin
                errors++;
                $display("FAIL fwd_rt_%0d got %0d want %0d", i, ctrl_rt, want[i]);
            end
            tick();
        end
    endtask

    task automatic test_load_use();
        drive(6'd35, 5'd0, 5'd5, 5'd5, 1, 1, 0, 0, 0, 0);
        tick();
        drive(6'd0, 5'd5, 5'd0, 5'd6, 1, 0, 0, 0, 0, 0);
        checks++;
        if ({pc_we, if_we, id_we, id_flush} !== 4'b0001) begin
            errors++;
            $display("FAIL loaduse_stall got %b want 0001", {pc_we, if_we, id_we, id_flush});
        end
        tick();
        drive(6'd0, 5'd5, 5'd0, 5'd6, 1, 0, 0, 0, 0, 0);
        checks++;
        if ({ctrl_rs, id_we, id_flush} !== 4'b1010) begin
            errors++;
            $display("FAIL loaduse_resume got %b want 1010", {ctrl_rs, id_we, id_flush});
        end
        tick();
        idle(3);
        drive(6'd35, 5'd0, 5'd5, 5'd5, 1, 1, 0, 0, 0, 0);
        tick();
        drive(6'd2, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({pc_we, id_we, id_flush} !== 3'b110) begin
            errors++;
            $display("FAIL jump_no_stall got %b want 110", {pc_we, id_we, id_flush});
        end
        tick();
        idle(3);
    endtask

    task automatic test_zero();
        drive(6'd35, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 0, 0);
        tick();
        drive(6'd0, 5'd0, 5'd0, 5'd7, 1, 0, 0, 0, 0, 0);
        checks++;
        if ({ctrl_rs, ctrl_rt, pc_we, id_we, id_flush} !== 7'b0000110) begin
            errors++;
            $display("FAIL reg_zero got %b want 0000110", {ctrl_rs, ctrl_rt, pc_we, id_we, id_flush});
        end
        tick();
        idle(3);
    endtask

    task automatic test_freeze();
        drive(6'd35, 5'd0, 5'd5, 5'd5, 1, 1, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(6'd0, 5'd5, 5'd0, 5'd6, 1, 0, 0, 0, 1, 0);
            checks++;
            if ({pc_we, if_we, id_we, if_flush, id_flush, exc_take, ctrl_rs} !== 8'b00000001) begin
                errors++;
                $display("FAIL freeze_%0d got %b want 00000001", i,
                         {pc_we, if_we, id_we, if_flush, id_flush, exc_take, ctrl_rs});
            end
            tick();
        end
        drive(6'd0, 5'd5, 5'd0, 5'd6, 1, 0, 0, 0, 0, 0);
        checks++;
        if ({pc_we, id_we, id_flush} !== 3'b001) begin
            errors++;
            $display("FAIL freeze_stall got %b want 001", {pc_we, id_we, id_flush});
        end
        tick();
        drive(6'd0, 5'd5, 5'd0, 5'd6, 1, 0, 0, 0, 0, 0);
        checks++;
        if ({ctrl_rs, id_we} !== 3'b101) begin
            errors++;
            $display("FAIL freeze_resume got %b want 101", {ctrl_rs, id_we});
        end
        tick();
        idle(3);
    endtask

    task automatic test_exc_redirect();
        drive(6'd0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0, 0);
        checks++;
        if ({pc_we, if_flush, id_flush, exc_take} !== 4'b0110) begin
            errors++;
            $display("FAIL exc_first got %b want 0110", {pc_we, if_flush, id_flush, exc_take});
        end
        tick();
        for (int c = 1; c <= DC + 1; c++) begin
            drive(6'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
            checks++;
            if ({exc_take, pc_we} !== ((c == DC + 1) ? 2'b11 : 2'b00)) begin
                errors++;
                $display("FAIL exc_cycle_%0d got %b want %b", c, {exc_take, pc_we},
                         (c == DC + 1) ? 2'b11 : 2'b00);
            end
            tick();
        end
        drive(6'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({exc_take, pc_we} !== 2'b01) begin
            errors++;
            $display("FAIL exc_after got %b want 01", {exc_take, pc_we});
        end
        tick();
    endtask

    task automatic test_reset_drain();
        int takes = 0;
        drive(6'd0, 5'd0, 5'd0, 5'd7, 1, 0, 0, 0, 0, 0);
        tick();
        drive(6'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0);
        tick();
        drive(6'd0, 5'd7, 5'd7, 5'd0, 0, 0, 0, 0, 0, 1);
        tick();
        drive(6'd0, 5'd7, 5'd7, 5'd0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({pc_we, if_we, id_we, if_flush, id_flush, ctrl_rs, ctrl_rt} !== 9'b111000000) begin
            errors++;
            $display("FAIL reset_drain got %b want 111000000",
                     {pc_we, if_we, id_we, if_flush, id_flush, ctrl_rs, ctrl_rt});
        end
        tick();
        for (int i = 0; i < 6; i++) begin
            drive(6'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0);
            takes += int'(exc_take);
            tick();
        end
        checks++;
        if (takes != 0) begin
            errors++;
            $display("FAIL reset_drain_take got %0d want 0", takes);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            drive(6'($urandom_range(0, 3) == 0 ? 35 : ($urandom_range(0, 1) ? 0 : $urandom_range(0, 63))),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 59) == 0));
            checks++;
            if ({pc_we, if_we, id_we, if_flush, id_flush, ctrl_rs, ctrl_rt, exc_take} !==
                {e_pc, e_if, e_id, e_iff, e_idf, e_rs, e_rt, e_take}) begin
                errors++;
                $display("FAIL random_%0d got %b want %b", n,
                         {pc_we, if_we, id_we, if_flush, id_flush, ctrl_rs, ctrl_rt, exc_take},
                         {e_pc, e_if, e_id, e_iff, e_idf, e_rs, e_rt, e_take});
            end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) sb[i] = '{0, 0, 0, 0};
        m_exc = 0;
        m_left = 0;
        test_reset();
        test_fwd_chain();
        test_load_use();
        test_zero();
        test_freeze();
        test_exc_redirect();
        test_reset_drain();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
